// File: rtl/avalon_interface.sv
// Avalon-MM slave front end for the accelerator core.
// Per-beat waitrequest handshake, scratch regs, control/status, result and memory windows.
module avalon_interface #(
  parameter int NUM_REGS = 16,
  parameter int MEM_AW   = 9
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        write,
  input  logic        read,
  input  logic        beginbursttransfer,
  input  logic [9:0]  burstcount,
  input  logic [10:0] address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        readdatavalid,
  output logic        writeresponsevalid,
  output logic [1:0]  response,
  output logic        waitrequest,
  input  logic [16:0] result_output,
  input  logic        done_calc,
  output logic [3:0]  output_address,
  output logic        start_calc,
  output logic [10:0] pixel_address,
  output logic [10:0] weight_address,
  output logic        w_enable_pixels,
  output logic        w_enable_weights,
  output logic [15:0] store_data
);

  localparam int RAW = $clog2(NUM_REGS);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCEPT = 2'd1;
  localparam logic [1:0] S_GAP    = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        is_rd_q, is_rd_d;
  logic        burst_q, burst_d;
  logic [10:0] base_q, base_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [9:0]  beat_q, beat_d;
  logic        err_q, err_d;
  logic        sticky_q, sticky_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] regs_q [NUM_REGS];
  logic [31:0] regs_d [NUM_REGS];

  logic [10:0] beat_addr;
  logic        acc, wr_beat, rd_beat;
  logic        hit_reg, hit_ctl, hit_res;
  logic        hit_pix, hit_wgt, unmapped;
  logic [31:0] rd_val;
  logic        more;

  // Decode the address of the beat currently being offered.
  always_comb begin
    beat_addr = base_q + {1'b0, beat_q};
    acc       = (state_q == S_ACCEPT);
    wr_beat   = acc & ~is_rd_q;
    rd_beat   = acc & is_rd_q;
    hit_reg   = (beat_addr < 11'(NUM_REGS));
    hit_ctl   = (beat_addr == 11'h010);
    hit_res   = (beat_addr[10:4] == 7'h02);
    hit_pix   = (beat_addr[10:9] == 2'b10);
    hit_wgt   = (beat_addr[10:9] == 2'b11);
    unmapped  = ~(hit_reg | hit_ctl | hit_res
                  | hit_pix | hit_wgt);
    rd_val    = '0;
    unique case (1'b1)
      hit_reg: rd_val = regs_q[beat_addr[RAW-1:0]];
      hit_ctl: rd_val = {30'b0, sticky_q, done_calc};
      hit_res: rd_val = {15'b0, result_output};
      default: rd_val = '0;
    endcase
    more = burst_q &
           (({1'b0, beat_q} + 11'd1) < {1'b0, cnt_q});
  end

  // Fabric-facing and core-facing outputs, all quiet outside their beat.
  always_comb begin
    waitrequest        = ~acc;
    readdatavalid      = (state_q == S_RESP) & is_rd_q;
    writeresponsevalid = (state_q == S_RESP) & ~is_rd_q;
    response           = (state_q == S_RESP) ? {2{err_q}} : 2'b00;
    readdata           = rdata_q;
    start_calc         = wr_beat & hit_ctl & writedata[0];
    w_enable_pixels    = wr_beat & hit_pix;
    w_enable_weights   = wr_beat & hit_wgt;
    pixel_address      = wr_beat ? 11'(beat_addr[MEM_AW-1:0]) : '0;
    weight_address     = wr_beat ? 11'(beat_addr[MEM_AW-1:0]) : '0;
    store_data         = wr_beat ? writedata[15:0] : '0;
    output_address     = (rd_beat & hit_res) ? beat_addr[3:0] : '0;
  end

  // Handshake FSM, burst tracking and register updates.
  always_comb begin
    state_d  = state_q;
    is_rd_d  = is_rd_q;
    burst_d  = burst_q;
    base_d   = base_q;
    cnt_d    = cnt_q;
    beat_d   = beat_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    regs_d   = regs_q;
    sticky_d = start_calc ? 1'b0 :
               (done_calc ? 1'b1 : sticky_q);
    unique case (state_q)
      S_IDLE: begin
        if (read | write) begin
          state_d = S_ACCEPT;
          is_rd_d = read;
          burst_d = write & ~read & beginbursttransfer;
          base_d  = address;
          cnt_d   = (burstcount == 10'd0) ? 10'd1 : burstcount;
          beat_d  = '0;
          err_d   = 1'b0;
        end
      end
      S_ACCEPT: begin
        err_d = err_q | unmapped;
        if (rd_beat) rdata_d = rd_val;
        if (wr_beat & hit_reg)
          regs_d[beat_addr[RAW-1:0]] = writedata;
        if (more) begin
          state_d = S_GAP;
          beat_d  = beat_q + 10'd1;
        end else begin
          state_d = S_RESP;
        end
      end
      S_GAP:   state_d = S_ACCEPT;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any burst without a response.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state_q  <= S_IDLE;
      is_rd_q  <= 1'b0;
      burst_q  <= 1'b0;
      base_q   <= '0;
      cnt_q    <= '0;
      beat_q   <= '0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
      rdata_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      is_rd_q  <= is_rd_d;
      burst_q  <= burst_d;
      base_q   <= base_d;
      cnt_q    <= cnt_d;
      beat_q   <= beat_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
      rdata_q  <= rdata_d;
      regs_q   <= regs_d;
    end
  end

endmodule

// File: tb/tb_avalon_interface.sv
// Directed bench for avalon_interface.
// Host-side tasks drive single and burst transfers and check every handshake.
module tb_avalon_interface;

  logic        clk = 1'b0;
  logic        n_rst = 1'b1;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic        beginbursttransfer = 1'b0;
  logic [9:0]  burstcount = '0;
  logic [10:0] address = '0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic        writeresponsevalid;
  logic [1:0]  response;
  logic        waitrequest;
  logic [16:0] result_output = '0;
  logic        done_calc = 1'b0;
  logic [3:0]  output_address;
  logic        start_calc;
  logic [10:0] pixel_address;
  logic [10:0] weight_address;
  logic        w_enable_pixels;
  logic        w_enable_weights;
  logic [15:0] store_data;

  int n_checks = 0;
  int n_fails  = 0;
  int pix_cnt  = 0;
  int wgt_cnt  = 0;
  int start_cnt = 0;

  avalon_interface dut (
    .clk(clk), .n_rst(n_rst),
    .write(write), .read(read),
    .beginbursttransfer(beginbursttransfer),
    .burstcount(burstcount), .address(address),
    .writedata(writedata), .readdata(readdata),
    .readdatavalid(readdatavalid),
    .writeresponsevalid(writeresponsevalid),
    .response(response), .waitrequest(waitrequest),
    .result_output(result_output), .done_calc(done_calc),
    .output_address(output_address), .start_calc(start_calc),
    .pixel_address(pixel_address),
    .weight_address(weight_address),
    .w_enable_pixels(w_enable_pixels),
    .w_enable_weights(w_enable_weights),
    .store_data(store_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (w_enable_pixels)  pix_cnt++;
    if (w_enable_weights) wgt_cnt++;
    if (start_calc)       start_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_accept(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (!waitrequest) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_write(input logic [10:0] a, input logic [31:0] d,
                          output logic [1:0] rsp, output logic st);
    bit ok;
    address = a; writedata = d; write = 1'b1;
    wait_accept(ok);
    chk("wr_accept", 32'(ok), 1);
    st = start_calc;
    @(posedge clk); #1;
    write = 1'b0;
    chk("wr_one_accept", 32'(waitrequest), 1);
    chk("wr_rsp_valid", 32'(writeresponsevalid), 1);
    rsp = response;
    @(posedge clk); #1;
    chk("wr_rsp_pulse", 32'(writeresponsevalid), 0);
  endtask

  task automatic do_read(input logic [10:0] a, output logic [31:0] d,
                         output logic [1:0] rsp, output logic [3:0] oa);
    bit ok;
    address = a; read = 1'b1;
    wait_accept(ok);
    chk("rd_accept", 32'(ok), 1);
    oa = output_address;
    chk("rd_no_early_valid", 32'(readdatavalid), 0);
    @(posedge clk); #1;
    read = 1'b0;
    chk("rd_valid", 32'(readdatavalid), 1);
    d = readdata;
    rsp = response;
    @(posedge clk); #1;
    chk("rd_valid_pulse", 32'(readdatavalid), 0);
  endtask

  task automatic do_burst(input logic [10:0] base, input int n,
                          input bit pix, output logic [1:0] rsp);
    bit ok;
    address = base; burstcount = 10'(n); writedata = 0;
    beginbursttransfer = 1'b1; write = 1'b1;
    for (int k = 0; k < n; k++) begin
      wait_accept(ok);
      chk("bst_accept", 32'(ok), 1);
      beginbursttransfer = 1'b0;
      if (pix) begin
        chk("bst_pix_we", 32'(w_enable_pixels), 1);
        chk("bst_pix_addr", 32'(pixel_address), k);
        chk("bst_pix_data", 32'(store_data), k);
      end
      @(posedge clk); #1;
      writedata = k + 1;
      if (k < n - 1)
        chk("bst_gap_no_rsp", 32'(writeresponsevalid), 0);
    end
    write = 1'b0;
    chk("bst_rsp_valid", 32'(writeresponsevalid), 1);
    rsp = response;
    @(posedge clk); #1;
  endtask

  logic [31:0] d;
  logic [1:0]  rsp;
  logic [3:0]  oa;
  logic        st;
  bit          ok;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_waitreq", 32'(waitrequest), 1);
    chk("rst_rdv", 32'(readdatavalid), 0);
    chk("rst_wrv", 32'(writeresponsevalid), 0);
    chk("rst_resp", 32'(response), 0);
    chk("rst_rdata", readdata, 0);
    chk("rst_start", 32'(start_calc), 0);
    chk("rst_we", 32'({w_enable_pixels, w_enable_weights}), 0);
    chk("rst_store", 32'(store_data), 0);
    n_rst = 1'b0;
    @(posedge clk); #1;

    do_write(11'h001, 32'h8, rsp, st);
    chk("w1_resp", 32'(rsp), 0);
    do_read(11'h001, d, rsp, oa);
    chk("r1_data", d, 32'h8);
    chk("r1_resp", 32'(rsp), 0);

    do_burst(11'h000, 10, 1'b0, rsp);
    chk("bst_reg_resp", 32'(rsp), 0);
    for (int i = 0; i < 10; i++) begin
      do_read(11'(i), d, rsp, oa);
      chk("bst_reg_rb", d, i);
    end

    pix_cnt = 0;
    do_burst(11'h400, 10, 1'b1, rsp);
    chk("bst_pix_resp", 32'(rsp), 0);
    chk("bst_pix_cnt", pix_cnt, 10);
    chk("bst_wgt_cnt", wgt_cnt, 0);

    do_write(11'h610, 32'h1234, rsp, st);
    chk("wgt_cnt", wgt_cnt, 1);

    start_cnt = 0;
    do_write(11'h010, 32'h1, rsp, st);
    chk("start_seen", 32'(st), 1);
    chk("start_cnt", start_cnt, 1);
    do_read(11'h010, d, rsp, oa);
    chk("status_pre", d, 0);
    done_calc = 1'b1;
    @(posedge clk); #1;
    done_calc = 1'b0;
    do_read(11'h010, d, rsp, oa);
    chk("status_sticky", d, 32'h2);

    result_output = 17'h1ABCD;
    do_read(11'h025, d, rsp, oa);
    chk("res_oaddr", 32'(oa), 5);
    chk("res_data", d, 32'h0001ABCD);
    chk("res_resp", 32'(rsp), 0);

    do_read(11'h100, d, rsp, oa);
    chk("unm_resp", 32'(rsp), 3);
    chk("unm_data", d, 0);
    do_write(11'h100, 32'h55, rsp, st);
    chk("unm_wr_resp", 32'(rsp), 3);
    do_read(11'h400, d, rsp, oa);
    chk("pix_rd_data", d, 0);
    chk("pix_rd_resp", 32'(rsp), 0);

    do_burst(11'h00E, 4, 1'b0, rsp);
    chk("bst_part_unm", 32'(rsp), 3);
    do_read(11'h00F, d, rsp, oa);
    chk("bst_part_reg", d, 1);

    pix_cnt = 0;
    address = 11'h400; burstcount = 10'd10; writedata = 0;
    beginbursttransfer = 1'b1; write = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_accept(ok);
      chk("abort_accept", 32'(ok), 1);
      beginbursttransfer = 1'b0;
      if (k == 3) break;
      @(posedge clk); #1;
      writedata = k + 1;
    end
    n_rst = 1'b1;
    write = 1'b0;
    #1;
    chk("abort_waitreq", 32'(waitrequest), 1);
    chk("abort_we", 32'(w_enable_pixels), 0);
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("abort_no_rsp", 32'(writeresponsevalid), 0);
      chk("abort_idle_wr", 32'(waitrequest), 1);
    end
    chk("abort_pix_cnt", pix_cnt, 3);
    do_read(11'h001, d, rsp, oa);
    chk("abort_regs_clr", d, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
